// File: rtl/bullet_collision_scanner_pkg.sv
// Shared definitions for the bullet collision scanner: colour codes,
// byte-lane slices of the packed pos/size words, and scanner FSM states.
package bullet_pkg;

  localparam logic [1:0] COL_WHITE = 2'b00;
  localparam logic [1:0] COL_GREEN = 2'b01;
  localparam logic [1:0] COL_BLUE  = 2'b10;

  localparam int X_HI = 15;
  localparam int X_LO = 8;
  localparam int Y_HI = 7;
  localparam int Y_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DEAD = 2'd2
  } state_e;

endpackage

// File: rtl/bullet_collision_scanner_box_overlap.sv
// Combinational axis-aligned box overlap test. Edge sums are 9 bits wide so
// boxes near 0xFF never wrap; touching edges do not count as overlap.
module box_overlap (
  input  logic [7:0] ax_i,
  input  logic [7:0] ay_i,
  input  logic [7:0] aw_i,
  input  logic [7:0] ah_i,
  input  logic [7:0] bx_i,
  input  logic [7:0] by_i,
  input  logic [7:0] bw_i,
  input  logic [7:0] bh_i,
  output logic       overlap_o
);

  logic [8:0] a_xe, a_ye, b_xe, b_ye;

  assign a_xe = {1'b0, ax_i} + {1'b0, aw_i};
  assign a_ye = {1'b0, ay_i} + {1'b0, ah_i};
  assign b_xe = {1'b0, bx_i} + {1'b0, bw_i};
  assign b_ye = {1'b0, by_i} + {1'b0, bh_i};

  assign overlap_o = ({1'b0, bx_i} < a_xe) && ({1'b0, ax_i} < b_xe) &&
                     ({1'b0, by_i} < a_ye) && ({1'b0, ay_i} < b_ye);

endmodule

// File: rtl/bullet_collision_scanner.sv
// Walks the bullet table index, tests each live bullet against the player
// heart box, and turns hits into clear requests plus HP damage/heal updates.
module bullet_collision_scanner
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS   = 3,
  parameter int HP_MAX        = 20,
  parameter int DAMAGE        = 4,
  parameter int HEAL          = 2,
  parameter int IFRAME_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isRun,
  input  logic [15:0] playerPos,
  input  logic [15:0] playerSize,
  input  logic        playerMoving,
  output logic [2:0]  bulletIndex,
  input  logic [15:0] bulletPos,
  input  logic [15:0] bulletSize,
  input  logic [1:0]  bulletColor,
  input  logic        bulletRender,
  output logic        isCollide,
  output logic [7:0]  hp,
  output logic        isDead,
  output logic        hitPulse,
  output logic        healPulse
);

  localparam int         IW       = $clog2(IFRAME_CYCLES + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_BULLETS - 1);
  localparam logic [7:0] HP_FULL  = 8'(HP_MAX);
  localparam logic [7:0] DMG      = 8'(DAMAGE);
  localparam logic [8:0] HEAL_W   = 9'(HEAL);
  localparam logic [IW-1:0] IFR_LOAD = IW'(IFRAME_CYCLES);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    hp_q, hp_d;
  logic          dead_q, dead_d;
  logic          collide_q, collide_d;
  logic          hit_q, hit_d;
  logic          heal_q, heal_d;
  logic [IW-1:0] iframe_q, iframe_d;

  logic       overlap;
  logic       live_hit;
  logic       dmg_ok;
  logic       heal_ok;
  logic [8:0] heal_sum;

  box_overlap u_overlap (
    .ax_i      (playerPos[X_HI:X_LO]),
    .ay_i      (playerPos[Y_HI:Y_LO]),
    .aw_i      (playerSize[X_HI:X_LO]),
    .ah_i      (playerSize[Y_HI:Y_LO]),
    .bx_i      (bulletPos[X_HI:X_LO]),
    .by_i      (bulletPos[Y_HI:Y_LO]),
    .bw_i      (bulletSize[X_HI:X_LO]),
    .bh_i      (bulletSize[Y_HI:Y_LO]),
    .overlap_o (overlap)
  );

  assign live_hit = bulletRender && (bulletColor != 2'b11) && overlap;
  assign dmg_ok   = live_hit && (iframe_q == '0) &&
                    ((bulletColor == COL_WHITE) ||
                     ((bulletColor == COL_BLUE) && playerMoving));
  assign heal_ok  = live_hit && (bulletColor == COL_GREEN);
  assign heal_sum = {1'b0, hp_q} + HEAL_W;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hp_d      = hp_q;
    dead_d    = dead_q;
    collide_d = 1'b0;
    hit_d     = 1'b0;
    heal_d    = 1'b0;
    iframe_d  = (iframe_q != '0) ? iframe_q - 1'b1 : '0;

    if (!isRun) begin
      // Table is re-initialising: any pending clear is dropped.
      state_d = IDLE;
      idx_d   = '0;
      hp_d    = HP_FULL;
      dead_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          idx_d   = '0;
          hp_d    = HP_FULL;
          dead_d  = 1'b0;
        end
        SCAN: begin
          idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
          if (dmg_ok) begin
            collide_d = 1'b1;
            hit_d     = 1'b1;
            iframe_d  = IFR_LOAD;
            if (hp_q <= DMG) begin
              hp_d    = '0;
              dead_d  = 1'b1;
              state_d = DEAD;
            end else begin
              hp_d = hp_q - DMG;
            end
          end else if (heal_ok) begin
            collide_d = 1'b1;
            heal_d    = 1'b1;
            hp_d      = (heal_sum > {1'b0, HP_FULL}) ? HP_FULL : heal_sum[7:0];
          end
        end
        DEAD: begin
          state_d = DEAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hp_q      <= HP_FULL;
      dead_q    <= 1'b0;
      collide_q <= 1'b0;
      hit_q     <= 1'b0;
      heal_q    <= 1'b0;
      iframe_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hp_q      <= hp_d;
      dead_q    <= dead_d;
      collide_q <= collide_d;
      hit_q     <= hit_d;
      heal_q    <= heal_d;
      iframe_q  <= iframe_d;
    end
  end

  assign bulletIndex = idx_q;
  assign isCollide   = collide_q;
  assign hp          = hp_q;
  assign isDead      = dead_q;
  assign hitPulse    = hit_q;
  assign healPulse   = heal_q;

endmodule
